// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// cpu_run_controller
//
// Bring-up and test sequencer for the single-cycle CPU core. The controller:
//   - holds the core in reset while a program is streamed into instruction
//     memory through a valid/ready load port,
//   - keeps the core in reset for RST_CYC more cycles once the load is done,
//   - then gates the core clock enable to run freely, single-step, or halt,
//   - detects the "j 0" halt idiom (HALT_INST) and counts the cycles in which
//     the core was enabled.
//
// Optional feature (macro CYCLE_LIMIT_EN):
//   A watchdog that forces HALTED when a free run reaches MAX_CYC enabled
//   cycles. After a trip, run and step commands are ignored until the next
//   load. Without the macro there is no limit and MAX_CYC is unused.
//
// Ports
//   clock       in   1       system clock, rising edge
//   resetn      in   1       synchronous reset, active-high
//   load_start  in   1       pulse: begin a program load (IDLE or HALTED)
//   ld_valid    in   1       load word valid
//   ld_ready    out  1       controller accepts a load word
//   ld_data     in   32      program word
//   ld_last     in   1       final word of the program
//   imem_we     out  1       instruction memory write enable
//   imem_addr   out  ADDR_W  instruction memory word address
//   imem_wdata  out  32      instruction memory write data
//   cmd_run     in   1       pulse: free-run the core
//   cmd_step    in   1       pulse: execute one instruction
//   cmd_halt    in   1       pulse: stop the core
//   cpu_pc      in   32      core PC (debug only, not used by the logic)
//   cpu_inst    in   32      instruction currently presented to the core
//   cpu_rst     out  1       core reset, active-high
//   cpu_ce      out  1       core clock enable
//   state_o     out  3       IDLE=0 LOAD=1 RSTCPU=2 HALTED=3 RUN=4 STEP=5
//   done        out  1       sticky: HALT_INST executed
//   load_err    out  1       sticky: memory filled before ld_last
//   cycles      out  CNT_W   enabled-cycle count since the last load
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module cpu_run_controller #(
  parameter int          ADDR_W    = 5,
  parameter int          CNT_W     = 32,
  parameter int          RST_CYC   = 2,
  parameter logic [31:0] HALT_INST = 32'h0800_0000,
  parameter int          MAX_CYC   = 1000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic [31:0]       cpu_pc,
  input  logic [31:0]       cpu_inst,
  output logic              cpu_rst,
  output logic              cpu_ce,
  output logic [2:0]        state_o,
  output logic              done,
  output logic              load_err,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RSTCPU = 3'd2,
    S_HALTED = 3'd3,
    S_RUN    = 3'd4,
    S_STEP   = 3'd5
  } state_t;

  // Counter for the post-load reset hold; counts 0 .. RST_CYC-1.
  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [RCW-1:0]      rst_cnt, rst_cnt_n;
  logic                ld_ready_n;
  logic                imem_we_n;
  logic [ADDR_W-1:0]   imem_addr_n;
  logic [31:0]         imem_wdata_n;
  logic                cpu_rst_n;
  logic                cpu_ce_n;
  logic                done_n;
  logic                load_err_n;
  logic [CNT_W-1:0]    cycles_n;

  logic                handshake;
  logic                halt_hit;
  logic                cmd_ok;

  // The PC is only observed on a debugger; fold it away so it is not flagged.
  logic                pc_unused;
  assign pc_unused = ^cpu_pc;

`ifdef CYCLE_LIMIT_EN
  logic                wdog, wdog_n;
  assign cmd_ok = ~wdog;
`else
  logic [CNT_W-1:0]    max_cyc_unused;
  assign max_cyc_unused = CNT_W'(MAX_CYC);
  assign cmd_ok         = 1'b1;
`endif

  assign handshake = ld_valid & ld_ready;
  // cpu_ce is high exactly while the core executes, so this is "the
  // instruction executing this cycle is the halt idiom".
  assign halt_hit  = cpu_ce & (cpu_inst == HALT_INST);
  assign state_o   = state;

  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    rst_cnt_n    = rst_cnt;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    done_n       = done;
    load_err_n   = load_err;
    cycles_n     = cycles;
`ifdef CYCLE_LIMIT_EN
    wdog_n       = wdog;
`endif

    // Saturating count of enabled cycles.
    if (cpu_ce && (cycles != '1)) cycles_n = cycles + CNT_W'(1);

    unique case (state)
      S_IDLE: begin
        if (load_start) begin
          state_n    = S_LOAD;
          ptr_n      = '0;
          load_err_n = 1'b0;
        end
      end

      S_LOAD: begin
        if (handshake) begin
          imem_we_n    = 1'b1;
          imem_addr_n  = ptr;
          imem_wdata_n = ld_data;
          if (ld_last) begin
            state_n = S_RSTCPU;
          end else if (ptr == '1) begin
            // Last slot written without ld_last: stop, never wrap to 0.
            load_err_n = 1'b1;
            state_n    = S_RSTCPU;
          end else begin
            ptr_n = ptr + ADDR_W'(1);
          end
        end
      end

      S_RSTCPU: begin
        if (rst_cnt == RCW'(RST_CYC - 1)) state_n = S_HALTED;
        else                              rst_cnt_n = rst_cnt + RCW'(1);
      end

      S_HALTED: begin
        if (cmd_halt) begin
          state_n = S_HALTED;
        end else if (cmd_step && cmd_ok) begin
          state_n = S_STEP;
        end else if (cmd_run && cmd_ok) begin
          state_n = S_RUN;
        end else if (load_start) begin
          state_n    = S_LOAD;
          ptr_n      = '0;
          load_err_n = 1'b0;
`ifdef CYCLE_LIMIT_EN
          wdog_n     = 1'b0;
`endif
        end
      end

      S_RUN: begin
        if (halt_hit) begin
          done_n  = 1'b1;
          state_n = S_HALTED;
        end else if (cmd_halt) begin
          state_n = S_HALTED;
`ifdef CYCLE_LIMIT_EN
        end else if (cycles_n == CNT_W'(MAX_CYC)) begin
          // Stop so that exactly MAX_CYC enabled cycles have elapsed.
          wdog_n  = 1'b1;
          state_n = S_HALTED;
`endif
        end
      end

      S_STEP: begin
        // The single step always completes, even with cmd_halt present.
        if (halt_hit) done_n = 1'b1;
        state_n = S_HALTED;
      end

      default: state_n = S_IDLE;
    endcase

    // Entering the post-load reset starts a fresh execution record.
    if ((state_n == S_RSTCPU) && (state != S_RSTCPU)) begin
      rst_cnt_n = '0;
      cycles_n  = '0;
      done_n    = 1'b0;
    end

    // Registered outputs follow the state being entered.
    ld_ready_n = (state_n == S_LOAD);
    cpu_rst_n  = (state_n == S_IDLE) || (state_n == S_LOAD) || (state_n == S_RSTCPU);
    cpu_ce_n   = (state_n == S_RUN)  || (state_n == S_STEP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (resetn) begin
      state      <= S_IDLE;
      ptr        <= '0;
      rst_cnt    <= '0;
      ld_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      cpu_ce     <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
      cycles     <= '0;
`ifdef CYCLE_LIMIT_EN
      wdog       <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      rst_cnt    <= rst_cnt_n;
      ld_ready   <= ld_ready_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      cpu_rst    <= cpu_rst_n;
      cpu_ce     <= cpu_ce_n;
      done       <= done_n;
      load_err   <= load_err_n;
      cycles     <= cycles_n;
`ifdef CYCLE_LIMIT_EN
      wdog       <= wdog_n;
`endif
    end
  end

endmodule
